// File: rtl/regfile_wb_scheduler.sv
// Writeback arbiter for ALU and load results, with a pending-register scoreboard.
// Optional operand forwarding is enabled by defining BYPASS_EN.
module regfile_wb_scheduler (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [3:0]  a_reg,
  input  logic [15:0] a_data,
  input  logic        a_r0_en,
  input  logic [15:0] a_r0_data,
  input  logic        m_valid,
  output logic        m_ready,
  input  logic [3:0]  m_reg,
  input  logic [15:0] m_data,
  input  logic        alloc_en,
  input  logic [3:0]  alloc_reg,
  input  logic        alloc_r0,
  input  logic        rd_en,
  input  logic [3:0]  rd_reg1,
  input  logic [3:0]  rd_reg2,
  output logic        stall,
  output logic [3:0]  write_reg,
  output logic [15:0] write_data,
  output logic [15:0] r0,
  output logic [1:0]  reg_write
`ifdef BYPASS_EN
  ,
  output logic        fwd1_en,
  output logic [15:0] fwd1_data,
  output logic        fwd2_en,
  output logic [15:0] fwd2_data
`endif
);

  localparam logic GNT_A = 1'b0;
  localparam logic GNT_M = 1'b1;

  logic        last_grant;
  logic [15:0] busy;
  logic [15:0] set_mask;
  logic [15:0] clr_mask;
  logic        a_fire;
  logic        m_fire;

  // Round-robin: on a tie the side not served last wins.
  always_comb begin
    a_ready = reset & a_valid
            & (~m_valid | (last_grant == GNT_M));
    m_ready = reset & m_valid
            & (~a_valid | (last_grant == GNT_A));
  end

  assign a_fire = a_valid & a_ready;
  assign m_fire = m_valid & m_ready;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (alloc_en) set_mask[alloc_reg] = 1'b1;
    if (alloc_r0) set_mask[0] = 1'b1;
    if (a_fire) begin
      clr_mask[a_reg] = 1'b1;
      if (a_r0_en) clr_mask[0] = 1'b1;
    end
    if (m_fire) clr_mask[m_reg] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      busy       <= '0;
      last_grant <= GNT_M;
      write_reg  <= '0;
      write_data <= '0;
      r0         <= '0;
      reg_write  <= 2'b00;
    end else begin
      busy      <= (busy & ~clr_mask) | set_mask;
      reg_write <= 2'b00;
      if (a_fire) begin
        last_grant <= GNT_A;
        write_reg  <= a_reg;
        write_data <= a_data;
        reg_write  <= {a_r0_en, 1'b1};
        if (a_r0_en) r0 <= a_r0_data;
      end else if (m_fire) begin
        last_grant <= GNT_M;
        write_reg  <= m_reg;
        write_data <= m_data;
        reg_write  <= 2'b01;
      end
    end
  end

`ifdef BYPASS_EN
  logic [15:0] pend;

  always_comb begin
    fwd1_en   = 1'b0;
    fwd1_data = '0;
    fwd2_en   = 1'b0;
    fwd2_data = '0;
    if (reg_write[0] && write_reg == rd_reg1) begin
      fwd1_en   = 1'b1;
      fwd1_data = write_data;
    end else if (reg_write[1] && rd_reg1 == 4'd0) begin
      fwd1_en   = 1'b1;
      fwd1_data = r0;
    end
    if (reg_write[0] && write_reg == rd_reg2) begin
      fwd2_en   = 1'b1;
      fwd2_data = write_data;
    end else if (reg_write[1] && rd_reg2 == 4'd0) begin
      fwd2_en   = 1'b1;
      fwd2_data = r0;
    end
  end

  // Bits cleared by this cycle's transfer no longer hold up a read.
  assign pend  = busy & ~clr_mask;
  assign stall = rd_en
               & ((pend[rd_reg1] & ~fwd1_en)
               |  (pend[rd_reg2] & ~fwd2_en));
`else
  assign stall = rd_en & (busy[rd_reg1] | busy[rd_reg2]);
`endif

endmodule

// File: doc/regfile_wb_scheduler.md
REGFILE_WB_SCHEDULER -- requirements
Module: regfile_wb_scheduler

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; ports are listed clock and reset first, as name  direction  width  meaning.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-low reset; sampled on the rising edge of clk.
REQ-004 a_valid, a_ready  input/output  1/1  ALU writeback handshake.
REQ-005 a_reg, a_data, a_r0_en, a_r0_data  input  4/16/1/16  ALU destination, result, R0-write flag, R0 value (mul/div).
REQ-006 m_valid, m_ready  input/output  1/1  memory-load writeback handshake.
REQ-007 m_reg, m_data  input  4/16  load destination and load data.
REQ-008 alloc_en, alloc_reg, alloc_r0  input  1/4/1  decode marks a destination pending (R0 pending if alloc_r0).
REQ-009 rd_en, rd_reg1, rd_reg2  input  1/4/4  decode read request.
REQ-010 stall  output  1  read-after-write hazard on a pending register.
REQ-011 write_reg, write_data, r0, reg_write  output  4/16/16/2  register-file write port; reg_write 00 none, 01 write_data->write_reg, 10 r0 only, 11 both.
REQ-012 fwd1_en, fwd1_data, fwd2_en, fwd2_data  output  1/16/1/16  bypass, present only with BYPASS_EN.

Function
REQ-013 Transfer occurs on a rising edge where valid and ready are both high; ready is combinational from the valid inputs and arbiter state.
REQ-014 Only one requester is granted per cycle; a lone valid requester is granted.
REQ-015 When both are valid, the requester not granted last SHALL win (round-robin); last_grant updates only on a transfer.
REQ-016 A non-granted requester keeps valid and its payload stable; the block drops nothing.
REQ-017 The register-file outputs SHALL be registered: a transfer at edge N drives write_reg/write_data/r0/reg_write during cycle N..N+1 only.
REQ-018 reg_write is 00 in any cycle that follows no transfer.
REQ-019 An ALU transfer drives reg_write = {a_r0_en,1}; a memory transfer drives reg_write = 01 and r0 holds its prior value.
REQ-020 Scoreboard: a 16-bit busy mask; alloc_en sets busy[alloc_reg]; alloc_r0 sets busy[0].
REQ-021 A transfer clears busy[dest] (and busy[0] when a_r0_en) on the same edge that registers the write.
REQ-022 Simultaneous set and clear of the same bit: set wins.
REQ-023 stall = rd_en & (busy[rd_reg1] | busy[rd_reg2]), combinational; rd_en low gives stall = 0.
REQ-024 A read of a register being cleared on this edge still stalls unless BYPASS_EN is defined.

Reset
REQ-025 With reset low at a clk edge: busy = 0, last_grant = M (ALU wins the first tie), write_reg = 0, write_data = 0, r0 = 0, reg_write = 00.
REQ-026 During reset, a_ready = m_ready = 0 and no transfer occurs.
REQ-027 Reset mid-operation discards in-flight requests and pending bits without emitting a write.

Configuration
REQ-028 Macro BYPASS_EN defined: when the register-file write outputs match rd_reg1/rd_reg2 with reg_write[0] set, or match R0 with reg_write[1] set, fwdN_en = 1 and fwdN_data carries the written value.
REQ-029 Under BYPASS_EN, stall is suppressed for those matching registers, and for a register whose busy bit the same-cycle transfer clears.
REQ-030 Macro BYPASS_EN undefined: the fwd ports SHALL be absent and stall follows REQ-023/REQ-024.

Verification
REQ-031 Reset low for 2 edges, then high -> all outputs 0, reg_write = 00, stall = 0.
REQ-032 a_valid = 1, a_reg = 3, a_data = 16'h1234, m_valid = 0 -> next cycle write_reg = 3, write_data = 16'h1234, reg_write = 01.
REQ-033 Both valid for 4 cycles after reset -> grant order A, M, A, M; each payload is written exactly once.
REQ-034 alloc_en with alloc_reg = 5, then rd_en with rd_reg1 = 5 -> stall = 1 until the M transfer to reg 5, then stall = 0.
REQ-035 ALU transfer with a_r0_en = 1, a_r0_data = 16'hBEEF, a_reg = 2 -> reg_write = 11, r0 = 16'hBEEF, and busy[0] and busy[2] are cleared.
REQ-036 With BYPASS_EN, a write to reg 7 with data 16'h00AA and rd_reg2 = 7 in the same cycle -> fwd2_en = 1, fwd2_data = 16'h00AA, stall = 0.
